phase_seq_gen: RTL
==================

PHASE_SEQ_GEN -- requirements
Module: phase_seq_gen

Interface
REQ-001 Parameter NUM_PHASES, default 2: number of non-overlapping phase enables, legal range 2..8.
REQ-002 Parameter HIGH_CYC, default 1: cycles each phase enable stays high, legal range ≥1.
REQ-003 Parameter GAP_CYC, default 1: dead cycles after each phase, with all enables low, legal range ≥0.
REQ-004 Parameter CNT_W, default 16: width of the round-length and round-count fields.
REQ-005 clk  in  1  single clock for the block; all logic is rising-edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 start  in  1  begin a run; sampled only in IDLE or DONE.
REQ-008 stop  in  1  request a graceful stop at the end of the current round.
REQ-009 run_len  in  CNT_W  number of rounds to run; 0 means free-run; latched on an accepted start.
REQ-010 phase_en  out  NUM_PHASES  registered phase strobes; at most one bit is set in any cycle.
REQ-011 round_tick  out  1  one-cycle pulse in the final cycle of each completed round.
REQ-012 round_cnt  out  CNT_W  number of rounds completed since the last accepted start.
REQ-013 busy  out  1  high in the HIGH, GAP and HOLD states.
REQ-014 done  out  1  sticky; set when run_len rounds have completed.

Function
REQ-015 The FSM SHALL have the states IDLE, HIGH, GAP, HOLD and DONE.
REQ-016 A round SHALL run phase p = 0..NUM_PHASES-1 in order: phase_en[p]=1 for HIGH_CYC cycles, then GAP_CYC cycles with phase_en all zero.
REQ-017 When GAP_CYC=0, the GAP state SHALL be skipped, so phase p+1 starts in the cycle after the last high cycle of phase p.
REQ-018 If start is sampled high in IDLE or DONE at edge t, the block SHALL:
- latch run_len;
- clear round_cnt and done;
- drive phase_en[0]=1 from edge t+1.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 round_tick SHALL pulse in the last cycle of phase NUM_PHASES-1, meaning the last GAP cycle, or the last HIGH cycle when GAP_CYC=0.
REQ-021 round_cnt SHALL increment on the edge that ends a round and wrap modulo 2^CNT_W.
REQ-022 If the latched run_len is nonzero and round_cnt reaches it, the FSM SHALL enter DONE with done=1, busy=0 and phase_en=0.
REQ-023 When run_len=0, the block SHALL run until stop; the round_cnt wrap SHALL NOT terminate the run.
REQ-024 A stop pulse during busy SHALL be latched, and the current round SHALL complete before the FSM goes to IDLE with done=0.
REQ-025 The latched stop SHALL clear on entry to IDLE.
REQ-026 If the stop request and run_len completion land on the same round end, the FSM SHALL go to DONE with done=1.
REQ-027 If start and stop are sampled high together in IDLE or DONE, start SHALL win and stop SHALL be discarded.
REQ-028 In IDLE, DONE and HOLD, phase_en SHALL be 0.

Reset
REQ-029 On rst_n=0, the block SHALL, immediately and asynchronously:
- set the state to IDLE;
- drive phase_en=0, round_tick=0, round_cnt=0, busy=0 and done=0;
- clear the stop latch and the dwell counter.
REQ-030 Reset asserted mid-round SHALL abort the round with no further strobes.
REQ-031 After rst_n deasserts, the first start SHALL be honoured on the first rising edge.

Configuration
REQ-032 Macro PHASE_SEQ_STEP_EN defined SHALL add two input ports: step_mode (1 bit) and step (1 bit).
REQ-033 With PHASE_SEQ_STEP_EN defined and step_mode=1, each completed round that is not final SHALL enter HOLD instead of starting the next round.
REQ-034 In HOLD, a step pulse SHALL start the next round on the following edge.
REQ-035 In HOLD, a latched stop SHALL go to IDLE.
REQ-036 With PHASE_SEQ_STEP_EN undefined, the step_mode and step ports and the HOLD state SHALL be absent, and rounds SHALL run back-to-back.

Structure
REQ-037 Package phase_seq_pkg SHALL hold:
- the state enum;
- the phase-index width constant, $clog2(NUM_PHASES);
- the dwell-counter width constant, from the larger of HIGH_CYC and GAP_CYC.
REQ-038 Sub-module phase_seq_dwell SHALL implement the loadable down-counter used for the HIGH and GAP dwell, with an expiry flag.

Verification
REQ-039 Default parameters, run_len=3, start pulse → six rounds of phase_en pattern 01,00,10,00 are NOT expected; the bench SHALL see exactly 3 rounds of that 4-cycle pattern, round_tick×3, then done=1 and round_cnt=3 at cycle 13.
REQ-040 NUM_PHASES=4, HIGH_CYC=2, GAP_CYC=0, run_len=1 → phase_en 0001,0001,0010,0010,0100,0100,1000,1000, then done=1.
REQ-041 run_len=0, stop pulsed in cycle 2 of round 5 → round 5 completes, then IDLE, done=0, round_cnt=5.
REQ-042 rst_n driven low mid-HIGH of phase 1 → phase_en=0 and busy=0 in the same cycle; a start after release gives phase_en[0] one cycle later.
REQ-043 start held high for the whole run, then start and stop together in DONE → a restart occurs with round_cnt cleared to 0.
REQ-044 With PHASE_SEQ_STEP_EN defined, step_mode=1 and run_len=2 → HOLD after round 1, idle strobes until step, then round 2 and done=1.

Source files
------------

// File: rtl/phase_seq_pkg.sv
// phase_seq_pkg: shared state type and width helpers for the phase sequencer.
// Contents:
//   state_t      - FSM states; HOLD exists only when PHASE_SEQ_STEP_EN is defined
//   phase_idx_w  - phase-index width, $clog2(NUM_PHASES)
//   dwell_w      - dwell-counter width, sized from the larger of HIGH_CYC and GAP_CYC
// Build option: PHASE_SEQ_STEP_EN adds the HOLD state used by single-step mode.
package phase_seq_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HIGH,
        ST_GAP,
`ifdef PHASE_SEQ_STEP_EN
        ST_HOLD,
`endif
        ST_DONE
    } state_t;
    function automatic int phase_idx_w(input int num_phases);
        return (num_phases > 1) ? $clog2(num_phases) : 1;
    endfunction
    // The counter is loaded with (cycles - 1), so the larger dwell bounds the width.
    function automatic int dwell_w(input int high_cyc, input int gap_cyc);
        int m;
        m = (high_cyc > gap_cyc) ? high_cyc : gap_cyc;
        return (m > 1) ? $clog2(m) : 1;
    endfunction
endpackage

// File: rtl/phase_seq_dwell.sv
// phase_seq_dwell: loadable down-counter timing the HIGH and GAP dwell of each phase.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load load_val this cycle (takes priority over counting)
//   load_val    value to load, i.e. dwell length minus one
//   cnt         current count, holds at zero
//   expired     current cycle is the last one of the dwell
module phase_seq_dwell
    import phase_seq_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         expired
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end
    assign expired = (cnt == '0);
endmodule

// File: rtl/phase_seq_gen.sv
// phase_seq_gen: non-overlapping multi-phase enable sequencer with round counting.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, stop       begin a run / stop gracefully at the end of the current round
//   step_mode, step   (PHASE_SEQ_STEP_EN only) pause in HOLD between rounds, resume on step
//   run_len           rounds per run, 0 = free-run; latched on an accepted start
//   phase_en          registered one-hot phase strobes
//   round_tick        pulse in the last cycle of every completed round
//   round_cnt         rounds completed since the last accepted start (wraps)
//   busy              high in HIGH, GAP and HOLD
//   done              sticky, set when run_len rounds have completed
// Build option: define PHASE_SEQ_STEP_EN to add single-step mode and the HOLD state.
module phase_seq_gen
    import phase_seq_pkg::*;
#(
    parameter int NUM_PHASES = 2,
    parameter int HIGH_CYC   = 1,
    parameter int GAP_CYC    = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
`ifdef PHASE_SEQ_STEP_EN
    input  logic                  step_mode,
    input  logic                  step,
`endif
    input  logic [CNT_W-1:0]      run_len,
    output logic [NUM_PHASES-1:0] phase_en,
    output logic                  round_tick,
    output logic [CNT_W-1:0]      round_cnt,
    output logic                  busy,
    output logic                  done
);
    localparam int PW = phase_idx_w(NUM_PHASES);
    localparam int DW = dwell_w(HIGH_CYC, GAP_CYC);
    localparam logic [PW-1:0] LAST = PW'(NUM_PHASES - 1);
    localparam logic [DW-1:0] HIGH_LD = DW'(HIGH_CYC - 1);
    localparam logic [DW-1:0] GAP_LD = DW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [NUM_PHASES-1:0] ONE = NUM_PHASES'(1);
    state_t st, nst;
    logic [PW-1:0] ph, nph;
    logic [DW-1:0] ld_val, dcnt, ndcnt;
    logic [CNT_W-1:0] len_q, ncnt;
    logic stop_q, nstop, stop_any, ld, adv, expired, fin, ndone, nbusy, nlast, acc;
    phase_seq_dwell #(.W(DW)) u_dwell (
        .clk(clk),
        .rst_n(rst_n),
        .load(ld),
        .load_val(ld_val),
        .cnt(dcnt),
        .expired(expired)
    );
    assign acc = start && (st == ST_IDLE || st == ST_DONE);
    // A stop sampled on the round-ending edge itself still ends that round.
    assign stop_any = stop_q | stop;
    assign fin = (len_q != '0) && (round_cnt + 1'b1 == len_q);
    always_comb begin
        nst    = st;
        nph    = ph;
        ld     = 1'b0;
        ld_val = HIGH_LD;
        ncnt   = round_cnt;
        ndone  = done;
        nstop  = stop_q | (busy & stop);
        adv    = 1'b0;
        case (st)
            ST_IDLE, ST_DONE: if (start) begin
                nst   = ST_HIGH;
                nph   = '0;
                ld    = 1'b1;
                ncnt  = '0;
                ndone = 1'b0;
            end
            ST_HIGH: if (expired) begin
                if (GAP_CYC != 0) begin
                    nst    = ST_GAP;
                    ld     = 1'b1;
                    ld_val = GAP_LD;
                end else adv = 1'b1;
            end
            ST_GAP: adv = expired;
`ifdef PHASE_SEQ_STEP_EN
            ST_HOLD: if (stop_any) nst = ST_IDLE;
            else if (step) begin
                nst = ST_HIGH;
                nph = '0;
                ld  = 1'b1;
            end
`endif
            default: nst = ST_IDLE;
        endcase
        // End of a phase: move to the next phase, or close the round.
        if (adv) begin
            nst = ST_HIGH;
            ld  = 1'b1;
            if (ph != LAST) nph = ph + 1'b1;
            else begin
                nph  = '0;
                ncnt = round_cnt + 1'b1;
                if (fin) begin
                    nst   = ST_DONE;
                    ndone = 1'b1;
                end else if (stop_any) nst = ST_IDLE;
`ifdef PHASE_SEQ_STEP_EN
                else if (step_mode) nst = ST_HOLD;
`endif
            end
        end
        // Any stop seen while idle or done is discarded; start always wins there.
        if (nst == ST_IDLE || nst == ST_DONE) nstop = 1'b0;
        nbusy = (nst == ST_HIGH) || (nst == ST_GAP);
`ifdef PHASE_SEQ_STEP_EN
        nbusy = nbusy || (nst == ST_HOLD);
`endif
        // round_tick is registered, so predict whether the next cycle closes a round.
        ndcnt = ld ? ld_val : (expired ? '0 : dcnt - 1'b1);
        nlast = (nph == LAST) && (ndcnt == '0) &&
                (nst == ST_GAP || (nst == ST_HIGH && GAP_CYC == 0));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= ST_IDLE;
            ph         <= '0;
            stop_q     <= 1'b0;
            len_q      <= '0;
            phase_en   <= '0;
            round_tick <= 1'b0;
            round_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            st         <= nst;
            ph         <= nph;
            stop_q     <= nstop;
            if (acc) len_q <= run_len;
            phase_en   <= (nst == ST_HIGH) ? ONE << nph : '0;
            round_tick <= nlast;
            round_cnt  <= ncnt;
            busy       <= nbusy;
            done       <= ndone;
        end
    end
endmodule
